// File: rtl/vc_round_robin_scheduler.sv
// Round-robin drain of four VC FIFOs into one output FIFO, with a two-stage
// pop-to-push pipeline, pause handling and write-side continue enables.
module vc_round_robin_scheduler #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    enable,
  input  logic [3:0]              empty,
  input  logic                    out_almost_full,
  input  logic [4*DATA_WIDTH-1:0] vc_data,
  output logic [3:0]              pop,
  output logic                    push,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [3:0]              continuar,
  output logic [1:0]              grant,
  output logic [1:0]              state,
  output logic [CNT_WIDTH-1:0]    word_count
);

  localparam int unsigned NUM_VC = 4;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  next_state;
  logic [NUM_VC-1:0]       elig;
  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W-1:0]        cand;
  logic                    s1_valid;
  logic [IDX_W-1:0]        s1_idx;
  logic [DATA_WIDTH-1:0]   sel_data;

  assign state = state_q;

  // Eligibility (skip VCs popped last cycle, their flag lags), arbitration, next state
  always_comb begin
    elig       = ~empty & ~pop;
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    next_state = IDLE;
    for (int k = 1; k <= int'(NUM_VC); k++) begin
      cand = grant + IDX_W'(k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    if (out_almost_full) begin
      next_state = (state_q == IDLE) ? IDLE : PAUSE;
    end else if (enable && win_found) begin
      next_state = SERVE;
    end
  end

  // Read-data select for the word whose pop was sampled on the previous edge
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(NUM_VC); k++) begin
      if (s1_idx == IDX_W'(k)) begin
        sel_data = vc_data[k*int'(DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  // FSM state, registered pops/grant/continuar and the pop-to-push pipeline
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      pop        <= '0;
      grant      <= IDX_W'(3);
      continuar  <= '1;
      s1_valid   <= 1'b0;
      s1_idx     <= '0;
      push       <= 1'b0;
      data_out   <= '0;
      word_count <= '0;
    end else begin
      state_q   <= next_state;
      pop       <= '0;
      if (next_state == SERVE) begin
        pop   <= NUM_VC'(1) << win_idx;
        grant <= win_idx;
      end
      continuar <= (next_state == PAUSE) ? '0 : '1;
      // grant always names the VC of a non-zero pop
      s1_valid  <= |pop;
      s1_idx    <= grant;
      push      <= s1_valid;
      if (s1_valid) begin
        data_out   <= sel_data;
        word_count <= word_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
